// File: rtl/xc_malu_pkg.sv
// Shared definitions for the xc_malu request arbiter: op-bundle layout,
// sequencer state encoding and the op legality check.
package xc_malu_pkg;

  localparam int OP_W        = 16;
  localparam int OP_MUL      = 0;
  localparam int OP_PMUL     = 1;
  localparam int OP_DIV      = 2;
  localparam int OP_REM      = 3;
  localparam int OP_MACC     = 4;
  localparam int OP_MADD     = 5;
  localparam int OP_MSUB     = 6;
  localparam int OP_PW_LO    = 7;
  localparam int OP_PW_HI    = 11;
  localparam int OP_LHS_SIGN = 12;
  localparam int OP_RHS_SIGN = 13;
  localparam int OP_DREM_U   = 14;
  localparam int OP_CLMUL    = 15;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

  // The instruction field must select exactly one MALU operation.
  function automatic logic op_legal(input logic [OP_MSUB:OP_MUL] insn);
    return $countones(insn) == 1;
  endfunction

endpackage

// File: rtl/xc_malu_rr2.sv
// Two-way round-robin grant; the priority pointer moves to the other
// requester whenever a grant is actually accepted.
module xc_malu_rr2 (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       accept,
  output logic       grant,
  output logic       grant_valid
);

  logic pri_reg;

  assign grant_valid = |req;
  assign grant       = (req[0] & req[1]) ? pri_reg : req[1];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pri_reg <= 1'b0;
    end else if (accept) begin
      pri_reg <= ~grant;
    end
  end

endmodule

// File: rtl/xc_malu_arb.sv
// Arbiter and sequencer sharing one multi-cycle xc_malu between two
// requesters, with op legality check and a hung-MALU watchdog.
module xc_malu_arb
  import xc_malu_pkg::*;
#(
  parameter int TIMEOUT = 64
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            rq0_valid,
  output logic            rq0_ready,
  input  logic [31:0]     rq0_rs1,
  input  logic [31:0]     rq0_rs2,
  input  logic [31:0]     rq0_rs3,
  input  logic [OP_W-1:0] rq0_op,
  input  logic            rq1_valid,
  output logic            rq1_ready,
  input  logic [31:0]     rq1_rs1,
  input  logic [31:0]     rq1_rs2,
  input  logic [31:0]     rq1_rs3,
  input  logic [OP_W-1:0] rq1_op,
  output logic            rs0_valid,
  input  logic            rs0_ready,
  output logic [31:0]     rs0_result_1,
  output logic [31:0]     rs0_result_0,
  output logic            rs0_err,
  output logic            rs1_valid,
  input  logic            rs1_ready,
  output logic [31:0]     rs1_result_1,
  output logic [31:0]     rs1_result_0,
  output logic            rs1_err,
  output logic            malu_valid,
  output logic            malu_flush,
  input  logic            malu_ready,
  output logic [31:0]     malu_rs1,
  output logic [31:0]     malu_rs2,
  output logic [31:0]     malu_rs3,
  output logic [OP_W-1:0] malu_op,
  input  logic [31:0]     malu_result_1,
  input  logic [31:0]     malu_result_0
);

  localparam int WDOG_W = $clog2(TIMEOUT) + 1;

  state_t            state_reg, state_next;
  logic              grant, grant_valid;
  logic              accept, capture, abort, resp_ready;
  logic [31:0]       sel_rs1, sel_rs2, sel_rs3;
  logic [OP_W-1:0]   sel_op;
  logic [31:0]       rs1_reg, rs2_reg, rs3_reg;
  logic [OP_W-1:0]   op_reg;
  logic              owner_reg;
  logic [31:0]       result1_reg, result0_reg;
  logic              err_reg;
  logic [WDOG_W-1:0] wdog_reg;

  xc_malu_rr2 u_rr (
    .clock       (clock),
    .reset       (reset),
    .req         ({rq1_valid, rq0_valid}),
    .accept      (accept),
    .grant       (grant),
    .grant_valid (grant_valid)
  );

  assign sel_rs1    = grant ? rq1_rs1 : rq0_rs1;
  assign sel_rs2    = grant ? rq1_rs2 : rq0_rs2;
  assign sel_rs3    = grant ? rq1_rs3 : rq0_rs3;
  assign sel_op     = grant ? rq1_op  : rq0_op;
  assign resp_ready = owner_reg ? rs1_ready : rs0_ready;

  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    capture    = 1'b0;
    abort      = 1'b0;
    malu_valid = 1'b0;
    malu_flush = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (grant_valid) begin
          accept     = 1'b1;
          // Illegal ops skip the MALU and answer with an error directly.
          state_next = op_legal(sel_op[OP_MSUB:OP_MUL]) ? ST_ISSUE : ST_RESP;
        end
      end
      ST_ISSUE: begin
        malu_valid = 1'b1;
        if (malu_ready) begin
          malu_flush = 1'b1;
          capture    = 1'b1;
          state_next = ST_RESP;
        end else if (wdog_reg == WDOG_W'(TIMEOUT - 1)) begin
          malu_flush = 1'b1;
          abort      = 1'b1;
          state_next = ST_RESP;
        end
      end
      ST_RESP: begin
        if (resp_ready) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg   <= ST_IDLE;
      rs1_reg     <= '0;
      rs2_reg     <= '0;
      rs3_reg     <= '0;
      op_reg      <= '0;
      owner_reg   <= 1'b0;
      result1_reg <= '0;
      result0_reg <= '0;
      err_reg     <= 1'b0;
      wdog_reg    <= '0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        rs1_reg     <= sel_rs1;
        rs2_reg     <= sel_rs2;
        rs3_reg     <= sel_rs3;
        op_reg      <= sel_op;
        owner_reg   <= grant;
        result1_reg <= '0;
        result0_reg <= '0;
        err_reg     <= ~op_legal(sel_op[OP_MSUB:OP_MUL]);
        wdog_reg    <= '0;
      end
      if (state_reg == ST_ISSUE) begin
        wdog_reg <= wdog_reg + WDOG_W'(1);
      end
      if (capture) begin
        result1_reg <= malu_result_1;
        result0_reg <= malu_result_0;
        err_reg     <= 1'b0;
      end
      if (abort) begin
        err_reg <= 1'b1;
      end
    end
  end

  assign rq0_ready    = accept & ~grant;
  assign rq1_ready    = accept & grant;
  assign rs0_valid    = (state_reg == ST_RESP) & ~owner_reg;
  assign rs1_valid    = (state_reg == ST_RESP) & owner_reg;
  assign rs0_err      = rs0_valid & err_reg;
  assign rs1_err      = rs1_valid & err_reg;
  assign rs0_result_1 = rs0_valid ? result1_reg : '0;
  assign rs0_result_0 = rs0_valid ? result0_reg : '0;
  assign rs1_result_1 = rs1_valid ? result1_reg : '0;
  assign rs1_result_0 = rs1_valid ? result0_reg : '0;
  assign malu_rs1     = rs1_reg;
  assign malu_rs2     = rs2_reg;
  assign malu_rs3     = rs3_reg;
  assign malu_op      = op_reg;

endmodule

// File: tb/tb_xc_malu_arb.sv
// Directed bench for xc_malu_arb: a behavioural MALU stub with programmable
// latency (or hang), a vector table of single ops, and multi-cycle sequences.
module tb_xc_malu_arb;
  import xc_malu_pkg::*;

  localparam int TO = 8;

  logic        clock = 1'b0;
  logic        reset;
  logic [1:0]  rq_valid, rq_ready, rs_valid, rs_ready, rs_err;
  logic [31:0] rq_rs1 [2];
  logic [31:0] rq_rs2 [2];
  logic [31:0] rq_rs3 [2];
  logic [15:0] rq_op  [2];
  logic [31:0] rs0_r1, rs0_r0, rs1_r1, rs1_r0;
  logic        malu_valid, malu_flush, malu_ready;
  logic [31:0] malu_rs1, malu_rs2, malu_rs3, m_r1, m_r0;
  logic [15:0] malu_op;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int stub_lat = 0;
  int stub_cnt;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  xc_malu_arb #(.TIMEOUT(TO)) dut (
    .clock(clock), .reset(reset),
    .rq0_valid(rq_valid[0]), .rq0_ready(rq_ready[0]),
    .rq0_rs1(rq_rs1[0]), .rq0_rs2(rq_rs2[0]), .rq0_rs3(rq_rs3[0]), .rq0_op(rq_op[0]),
    .rq1_valid(rq_valid[1]), .rq1_ready(rq_ready[1]),
    .rq1_rs1(rq_rs1[1]), .rq1_rs2(rq_rs2[1]), .rq1_rs3(rq_rs3[1]), .rq1_op(rq_op[1]),
    .rs0_valid(rs_valid[0]), .rs0_ready(rs_ready[0]),
    .rs0_result_1(rs0_r1), .rs0_result_0(rs0_r0), .rs0_err(rs_err[0]),
    .rs1_valid(rs_valid[1]), .rs1_ready(rs_ready[1]),
    .rs1_result_1(rs1_r1), .rs1_result_0(rs1_r0), .rs1_err(rs_err[1]),
    .malu_valid(malu_valid), .malu_flush(malu_flush), .malu_ready(malu_ready),
    .malu_rs1(malu_rs1), .malu_rs2(malu_rs2), .malu_rs3(malu_rs3), .malu_op(malu_op),
    .malu_result_1(m_r1), .malu_result_0(m_r0)
  );

  // MALU stub: ready after stub_lat extra cycles of valid; negative = hang.
  always @(posedge clock or posedge reset) begin
    if (reset) stub_cnt <= 0;
    else if (!malu_valid || malu_flush) stub_cnt <= 0;
    else stub_cnt <= stub_cnt + 1;
  end
  assign malu_ready = malu_valid && (stub_lat >= 0) && (stub_cnt == stub_lat);

  logic signed [65:0] sa, sb, prod;
  always_comb begin
    sa   = $signed({malu_op[OP_LHS_SIGN] & malu_rs1[31], malu_rs1});
    sb   = $signed({malu_op[OP_RHS_SIGN] & malu_rs2[31], malu_rs2});
    prod = sa * sb;
    m_r1 = prod[63:32];
    m_r0 = prod[31:0];
    if (malu_op[OP_DIV] || malu_op[OP_REM]) begin
      m_r1 = 32'h0;
      if (malu_rs2 == 32'h0) m_r0 = malu_op[OP_DIV] ? 32'hFFFF_FFFF : malu_rs1;
      else if (malu_op[OP_LHS_SIGN])
        m_r0 = malu_op[OP_DIV] ? $signed(malu_rs1) / $signed(malu_rs2)
                               : $signed(malu_rs1) % $signed(malu_rs2);
      else m_r0 = malu_op[OP_DIV] ? malu_rs1 / malu_rs2 : malu_rs1 % malu_rs2;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    int          port;
    logic [15:0] op;
    logic [31:0] a, b, hi, lo;
    logic        err;
    int          exp_lat;
    int          lat;
  } vec_t;

  task automatic do_op(input int idx, input vec_t v);
    int t = 0, tv = 0, nflush = 0, nvalid = 0, other = 0;
    bit got = 0;
    logic [63:0] res = '0;
    logic e = 1'b0;
    stub_lat = v.lat;
    rq_rs1[v.port] = v.a; rq_rs2[v.port] = v.b; rq_rs3[v.port] = 32'h0;
    rq_op[v.port] = v.op; rq_valid[v.port] = 1'b1;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (rq_ready[v.port]) begin got = 1; t = cyc; break; end
      @(negedge clock);
    end
    check("accept", 64'(got), 64'd1);
    @(negedge clock);
    rq_valid[v.port] = 1'b0;
    got = 0;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (malu_flush) nflush++;
      if (malu_valid) nvalid++;
      if (rs_valid[1 - v.port]) other++;
      if (rs_valid[v.port]) begin
        got = 1; tv = cyc;
        res = v.port ? {rs1_r1, rs1_r0} : {rs0_r1, rs0_r0};
        e = rs_err[v.port];
        break;
      end
      @(negedge clock);
    end
    check("resp_seen", 64'(got), 64'd1);
    check("latency", 64'(tv - t), 64'(v.exp_lat));
    check("result", res, {v.hi, v.lo});
    check("err", 64'(e), 64'(v.err));
    check("flush_pulses", 64'(nflush), (v.exp_lat > 1) ? 64'd1 : 64'd0);
    check("malu_valid_cycles", 64'(nvalid), 64'(v.exp_lat - 1));
    check("other_port_idle", 64'(other), 64'd0);
    rs_ready[v.port] = 1'b1;
    @(negedge clock);
    rs_ready[v.port] = 1'b0;
    #1;
    check("resp_release", 64'(rs_valid), 64'd0);
    $display("op %0d port=%0d op=%h a=%h b=%h -> result=%h err=%b lat=%0d",
             idx, v.port, v.op, v.a, v.b, res, e, tv - t);
  endtask

  vec_t vt [10];
  int   order [4];
  int   n, overlap, stale;
  bit   got;

  initial begin
    vt[0] = '{0, 16'h0001, 32'd7,          32'd9, 32'h0,          32'h3F,         1'b0, 4, 2};
    vt[1] = '{1, 16'h3004, 32'd5,          32'd0, 32'h0,          32'hFFFF_FFFF,  1'b0, 3, 1};
    vt[2] = '{0, 16'h0000, 32'd1,          32'd2, 32'h0,          32'h0,          1'b1, 1, 0};
    vt[3] = '{1, 16'h0003, 32'd3,          32'd4, 32'h0,          32'h0,          1'b1, 1, 0};
    vt[4] = '{0, 16'h0001, 32'hFFFF_FFFF,  32'd2, 32'h1,          32'hFFFF_FFFE,  1'b0, 2, 0};
    vt[5] = '{0, 16'h0001, 32'd3,          32'd5, 32'h0,          32'h0,          1'b1, TO + 1, -1};
    vt[6] = '{0, 16'h0001, 32'd3,          32'd5, 32'h0,          32'd15,         1'b0, 3, 1};
    vt[7] = '{1, 16'h3001, 32'hFFFF_FFFE,  32'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFA,  1'b0, TO + 1, TO - 1};
    vt[8] = '{1, 16'h0004, 32'd100,        32'd7, 32'h0,          32'd14,         1'b0, TO, TO - 2};
    vt[9] = '{0, 16'h0081, 32'd6,          32'd7, 32'h0,          32'd42,         1'b0, 5, 3};

    reset = 1'b1;
    rq_valid = '0; rs_ready = '0;
    for (int p = 0; p < 2; p++) begin
      rq_rs1[p] = '0; rq_rs2[p] = '0; rq_rs3[p] = '0; rq_op[p] = '0;
    end
    @(negedge clock);
    check("rst_rq_ready", 64'(rq_ready), 64'd0);
    check("rst_rs_valid", 64'(rs_valid), 64'd0);
    check("rst_rs_err", 64'(rs_err), 64'd0);
    check("rst_malu_ctl", {62'd0, malu_valid, malu_flush}, 64'd0);
    check("rst_results", {rs0_r1 | rs1_r1, rs0_r0 | rs1_r0}, 64'd0);
    check("rst_operands", {malu_rs1 | malu_rs2, malu_rs3 | 32'(malu_op)}, 64'd0);
    reset = 1'b0;

    // Both ports held valid from reset: grants must alternate starting at 0.
    stub_lat = 0; rs_ready = 2'b11;
    rq_op[0] = 16'h0001; rq_rs1[0] = 32'd2; rq_rs2[0] = 32'd3;
    rq_op[1] = 16'h0001; rq_rs1[1] = 32'd4; rq_rs2[1] = 32'd5;
    rq_valid = 2'b11;
    n = 0; overlap = 0;
    for (int i = 0; i < 60 && n < 4; i++) begin
      #1;
      if ((rq_ready != 2'b00) && (rs_valid != 2'b00)) overlap++;
      if (rq_ready != 2'b00) begin
        check("grant_onehot", 64'($countones(rq_ready)), 64'd1);
        order[n] = int'(rq_ready[1]);
        n++;
      end
      @(negedge clock);
    end
    rq_valid = 2'b00;
    check("grant_count", 64'(n), 64'd4);
    for (int k = 0; k < 4; k++) begin
      check("grant_order", 64'(order[k]), 64'(k % 2));
      $display("rr grant %0d -> port %0d", k, order[k]);
    end
    check("accept_resp_overlap", 64'(overlap), 64'd0);
    repeat (4) @(negedge clock);
    rs_ready = 2'b00;

    for (int i = 0; i < 10; i++) do_op(i, vt[i]);

    // Reset during ISSUE with a hung MALU, response side never ready.
    stub_lat = -1;
    rq_op[0] = 16'h0001; rq_rs1[0] = 32'hDEAD_BEEF; rq_rs2[0] = 32'd3;
    rq_valid[0] = 1'b1;
    got = 0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (rq_ready[0]) begin got = 1; break; end
      @(negedge clock);
    end
    check("mid_accept", 64'(got), 64'd1);
    @(negedge clock);
    rq_valid[0] = 1'b0;
    @(negedge clock);
    #1;
    check("mid_issue", 64'(malu_valid), 64'd1);
    #1 reset = 1'b1;
    #1;
    check("async_malu_ctl", {62'd0, malu_valid, malu_flush}, 64'd0);
    check("async_operands", {malu_rs1, 16'd0, malu_op}, 64'd0);
    check("async_rs", {59'd0, rs_valid, rs_err, 1'b0}, 64'd0);
    @(negedge clock);
    reset = 1'b0;
    stub_lat = 0;
    stale = 0;
    repeat (3) begin
      @(negedge clock);
      #1;
      if (rs_valid != 2'b00 || malu_valid) stale++;
    end
    check("post_reset_idle", 64'(stale), 64'd0);
    $display("reset during issue: stale activity cycles=%0d", stale);
    rq_op[0] = 16'h0001; rq_rs1[0] = 32'd11; rq_rs2[0] = 32'd3;
    rq_op[1] = 16'h0001; rq_rs1[1] = 32'd13; rq_rs2[1] = 32'd3;
    rq_valid = 2'b11;
    #1;
    check("post_reset_grant", 64'(rq_ready), 64'd1);
    @(negedge clock);
    rq_valid = 2'b00;
    got = 0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (rs_valid[0]) begin got = 1; break; end
      @(negedge clock);
    end
    check("post_reset_resp", {31'd0, got, rs0_r0}, {31'd0, 1'b1, 32'd33});
    $display("post-reset op port=0 result=%h_%h err=%b", rs0_r1, rs0_r0, rs_err[0]);
    rs_ready[0] = 1'b1;
    @(negedge clock);
    rs_ready[0] = 1'b0;
    repeat (2) @(negedge clock);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL sim_time_limit: got running expected finished");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/xc_malu_arb.md
# xc_malu_arb

Two-port arbiter and sequencer for the shared xc_malu multi-cycle arithmetic unit. It accepts operation requests from two independent requesters, for example the base-ISA MUL/DIV path and the XCrypto packed-multiply path. It grants them round-robin and drives the xc_malu valid/flush/ready handshake, registering operands for the whole operation. Each result is held until the owning requester accepts it. It also guards against illegal op encodings and a hung MALU with a watchdog.

## Interface
- `TIMEOUT`, default 64: maximum cycles in ISSUE before abort (≥2).
- `clock`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `rqN_valid`  in  1  request valid, N∈{0,1}.
- `rqN_ready`  out  1  request accepted this cycle.
- `rqN_rs1`, `rqN_rs2`, `rqN_rs3`  in  32  operands.
- `rqN_op`  in  16  op bundle, one field per bit group:
  - `[6:0]` {msub,madd,macc,rem,div,pmul,mul}, one-hot required;
  - `[11:7]` pw;
  - `[12]` lhs_sign; `[13]` rhs_sign; `[14]` drem_unsigned; `[15]` carryless.
- `rsN_valid`  out  1  response valid.
- `rsN_ready`  in  1  response accepted.
- `rsN_result_1`, `rsN_result_0`  out  32  high and low result words.
- `rsN_err`  out  1  response is an error (illegal op or timeout).
- `malu_valid`  out  1  MALU inputs valid.
- `malu_flush`  out  1  MALU flush.
- `malu_ready`  in  1  MALU output ready.
- `malu_rs1/2/3`  out  32  registered operands.
- `malu_op`  out  16  registered op bundle, split at top level onto the MALU insn_*/pw/sign/carryless pins.
- `malu_result_1`, `malu_result_0`  in  32  MALU result.

## Operation
- State machine with states IDLE, ISSUE, RESP. Reset state is IDLE; priority pointer `pri` resets to 0.
- **IDLE:**
  - `grant` = the requester with valid set; if both are valid, the one selected by `pri`.
  - `rqN_ready` = (state==IDLE) && grant==N, combinational.
  - On accept: register rs1/2/3, op and owner; set `pri` = !owner.
  - If the op is valid, go to ISSUE. Otherwise (zero or multiple bits set in `op[6:0]`) go directly to RESP with err=1 and result 0; the MALU is never touched.
- **ISSUE:**
  - `malu_valid`=1; operands and op held stable from the registers.
  - Watchdog `wdog` clears on entry and increments each cycle.
  - If `malu_ready`: `malu_flush`=1 in the same cycle, capture `malu_result_1`/`malu_result_0`, err=0, go to RESP.
  - Else if `wdog`==TIMEOUT-1: `malu_flush`=1, result 0, err=1, go to RESP.
- **RESP:**
  - `rs<owner>_valid`=1 with the registered result and err. The other port's `rsN_valid` is 0.
  - On `rs<owner>_ready`, go to IDLE.
- `malu_flush`=0 and `malu_valid`=0 in all other states and cycles.
- No new request is accepted outside IDLE; a response and a new accept never occur in the same cycle.

## Timing
- Reset values:
  - all `rqN_ready`, `rsN_valid`, `rsN_err`, `malu_valid`, `malu_flush` = 0;
  - all result and operand outputs = 0;
  - `pri`=0, `wdog`=0.
- Asynchronous reset mid-operation returns to IDLE immediately and discards the in-flight op. The top level ties MALU `resetn` = !reset, so the MALU clears too.
- Latency:
  - accept at cycle T; `malu_valid` rises at T+1;
  - if `malu_ready` occurs at cycle R, `rsN_valid` rises at R+1;
  - illegal op: `rsN_valid` at T+1.
- Minimum occupancy per op is accept + 1 MALU cycle + RESP + 1 IDLE cycle.
- The watchdog abort flushes at T+TIMEOUT and the response appears at T+TIMEOUT+1.
- A requester may drop `rqN_valid` before it is granted; no state change results.

## Structure
- Package `xc_malu_pkg` holds:
  - `OP_W`=16 and the bit positions `OP_MUL`..`OP_MSUB`, `OP_PW_LO/HI`, `OP_LHS_SIGN`, `OP_RHS_SIGN`, `OP_DREM_U`, `OP_CLMUL`;
  - the state encodings `ST_IDLE`/`ST_ISSUE`/`ST_RESP`;
  - the function `op_legal` (popcount of `[6:0]`==1).
- One sub-module `xc_malu_rr2`: 2-way round-robin grant with the `pri` register and an update-on-accept input.
- The MALU instance lives outside this block.

## Test plan
- Port0 MUL unsigned, rs1=7, rs2=9, with a real MALU → rs0 result {0x0,0x3F}, err=0, exactly one `malu_flush` pulse.
- Port1 DIV signed, rs1=5, rs2=0 → rs1 result {0x0,0xFFFFFFFF}. Port0 is idle throughout with rs0_valid=0.
- Both ports valid in the same cycle after reset → port0 granted first and port1 second. Repeat 4 ops with both held valid → grants strictly alternate 0,1,0,1.
- Port0 op=0x0000 (no insn bit) → rq0_ready, then rs0_valid the next cycle with err=1 and result 0; `malu_valid` never asserted.
- MALU stub holding `malu_ready`=0, TIMEOUT=8 → `malu_flush` at T+8, rs0_err=1 at T+9; the next request then completes normally.
- Assert `reset` during ISSUE, then hold rs0_ready low → all outputs return to 0 asynchronously, state is IDLE, and the next request is granted to port0.
